// File: rtl/spm_port_arbiter.sv
// -----------------------------------------------------------------------------
// spm_port_arbiter
//
// Shares the memory-side SPM port (port B) between the pipeline MEM stage and a
// DMA engine. At most one single-word access is issued per cycle. MEM has fixed
// priority. A starvation counter forces one DMA grant after STARVE_MAX
// consecutive DMA denials. Read data arrives one cycle after the grant and is
// routed back to whichever requester issued the read.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   m_req/m_rw/m_addr/    MEM stage request (level), READ=1/WRITE=0, word
//   m_wr_data             address and write data
//   m_gnt, m_stall        MEM access issued this cycle / MEM stage must hold
//   m_rd_data, m_rd_vld   read return to MEM (cycle after a granted MEM read)
//   d_req/d_rw/d_addr/    DMA request (level), READ=1/WRITE=0, word address
//   d_wr_data             and write data
//   d_gnt                 DMA access issued this cycle
//   d_rd_data, d_rd_vld   read return to DMA (cycle after a granted DMA read)
//   spm_addr, spm_as_,    SPM port B address, active-low strobe, READ/WRITE,
//   spm_rw, spm_wr_data   write data
//   spm_rd_data           SPM port B registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module spm_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // MEM stage
  input  logic              m_req,
  input  logic              m_rw,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wr_data,
  output logic              m_gnt,
  output logic              m_stall,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_rd_vld,
  // DMA engine
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_rd_vld,
  // SPM port B
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  localparam logic        RwRead    = 1'b1;
  localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnMem  = 2'd1,
    OwnDma  = 2'd2
  } rd_owner_e;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  rd_owner_e  rd_owner_q, rd_owner_d;
  logic       dma_forced;

  // ---------------------------------------------------------------------------
  // Grant: combinational from the live requests and the registered starve count.
  // ---------------------------------------------------------------------------
  always_comb begin
    dma_forced = (starve_cnt_q == StarveMax);
    m_gnt      = 1'b0;
    d_gnt      = 1'b0;
    if (!reset) begin
      // MEM wins contention unless DMA has been denied STARVE_MAX times in a row.
      if (m_req && (!d_req || !dma_forced)) begin
        m_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  assign m_stall = m_req & ~m_gnt;

  // ---------------------------------------------------------------------------
  // SPM port mux: follows the granted requester in the same cycle; parked at a
  // quiet READ of address 0 with the strobe high when nothing is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    spm_as_     = 1'b1;
    spm_rw      = RwRead;
    spm_addr    = '0;
    spm_wr_data = '0;
    if (m_gnt) begin
      spm_as_     = 1'b0;
      spm_rw      = m_rw;
      spm_addr    = m_addr;
      spm_wr_data = m_wr_data;
    end else if (d_gnt) begin
      spm_as_     = 1'b0;
      spm_rw      = d_rw;
      spm_addr    = d_addr;
      spm_wr_data = d_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles DMA asked and lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!d_req || d_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return FSM: rd_owner names who owns the data SPM returns this cycle.
  // Every cycle loads the owner of the access just issued, so back-to-back
  // reads from alternating requesters pipeline at one per cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= OwnNone;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    rd_owner_d = OwnNone;
    if (m_gnt && (m_rw == RwRead)) begin
      rd_owner_d = OwnMem;
    end else if (d_gnt && (d_rw == RwRead)) begin
      rd_owner_d = OwnDma;
    end
  end

  // Gating with reset drops a read that was in flight when reset asserted.
  always_comb begin
    m_rd_vld  = !reset && (rd_owner_q == OwnMem);
    d_rd_vld  = !reset && (rd_owner_q == OwnDma);
    m_rd_data = m_rd_vld ? spm_rd_data : '0;
    d_rd_data = d_rd_vld ? spm_rd_data : '0;
  end

endmodule

// File: tb/tb_spm_port_arbiter.sv
module tb_spm_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_req, m_rw, m_gnt, m_stall, m_rd_vld;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr_data, m_rd_data;
  logic          d_req, d_rw, d_gnt, d_rd_vld;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wr_data, d_rd_data;
  logic [AW-1:0] spm_addr;
  logic          spm_as_, spm_rw;
  logic [DW-1:0] spm_wr_data, spm_rd_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .reset      (reset),
    .m_req      (m_req),
    .m_rw       (m_rw),
    .m_addr     (m_addr),
    .m_wr_data  (m_wr_data),
    .m_gnt      (m_gnt),
    .m_stall    (m_stall),
    .m_rd_data  (m_rd_data),
    .m_rd_vld   (m_rd_vld),
    .d_req      (d_req),
    .d_rw       (d_rw),
    .d_addr     (d_addr),
    .d_wr_data  (d_wr_data),
    .d_gnt      (d_gnt),
    .d_rd_data  (d_rd_data),
    .d_rd_vld   (d_rd_vld),
    .spm_addr   (spm_addr),
    .spm_as_    (spm_as_),
    .spm_rw     (spm_rw),
    .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data)
  );

  // SPM port B behavioural model: registered read, write-first.
  logic [DW-1:0] spm_mem [Depth];
  logic [DW-1:0] spm_rd_q;
  assign spm_rd_data = spm_rd_q;

  always @(posedge clk) begin
    if (!spm_as_) begin
      if (spm_rw) begin
        spm_rd_q <= spm_mem[spm_addr];
      end else begin
        spm_mem[spm_addr] <= spm_wr_data;
        spm_rd_q          <= spm_wr_data;
      end
    end
  end

  // Reference memory owned by the scoreboard, updated only from predicted grants.
  logic [DW-1:0] ref_mem [Depth];

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return DW'(i * 32'h9E37_79B9 + 32'h1234_5678);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit            is_dma;
    logic [DW-1:0] data;
    int unsigned   due;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model: grants from the priority/starvation rules, read data from
  // the reference memory, expected returns pushed into the scoreboard queue.
  // ---------------------------------------------------------------------------
  int unsigned denials = 0;

  always @(negedge clk) begin : model
    bit            em, ed;
    logic [127:0]  exp_port, act_port;
    rd_exp_t       e;
    if (reset) begin
      em = 1'b0;
      ed = 1'b0;
    end else if (m_req && d_req) begin
      ed = (denials == SM);
      em = !ed;
    end else begin
      em = m_req;
      ed = d_req;
    end
    check("grant", {m_gnt, d_gnt}, {em, ed});
    check("stall", m_stall, m_req && !em);
    act_port = {spm_as_, spm_rw, spm_addr, spm_wr_data};
    if (em)      exp_port = {1'b0, m_rw, m_addr, m_wr_data};
    else if (ed) exp_port = {1'b0, d_rw, d_addr, d_wr_data};
    else         exp_port = {1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}};
    check("spm_port", act_port, exp_port);

    if (reset || !d_req || ed) denials = 0;
    else if (denials < SM)     denials++;

    if (em) begin
      if (m_rw) begin
        e.is_dma = 1'b0; e.data = ref_mem[m_addr]; e.due = cyc + 1;
        exp_q.push_back(e);
      end else begin
        ref_mem[m_addr] = m_wr_data;
      end
    end else if (ed) begin
      if (d_rw) begin
        e.is_dma = 1'b1; e.data = ref_mem[d_addr]; e.due = cyc + 1;
        exp_q.push_back(e);
      end else begin
        ref_mem[d_addr] = d_wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares read returns against the scoreboard queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (reset) begin
      check("rst_no_vld", {m_rd_vld, d_rd_vld}, 2'b00);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
    end else if (m_rd_vld || d_rd_vld) begin
      if (exp_q.size() == 0) begin
        check("vld_unexpected", {m_rd_vld, d_rd_vld}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("rd_who", {m_rd_vld, d_rd_vld}, e.is_dma ? 2'b01 : 2'b10);
        check("rd_due", cyc, e.due);
        check("rd_data", e.is_dma ? d_rd_data : m_rd_data, e.data);
        check("rd_other_zero", e.is_dma ? m_rd_data : d_rd_data, '0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check("vld_missing", {m_rd_vld, d_rd_vld}, e.is_dma ? 2'b01 : 2'b10);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic req, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    m_req = req; m_rw = rw; m_addr = a; m_wr_data = wd;
  endtask

  task automatic set_d(input logic req, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    d_req = req; d_rw = rw; d_addr = a; d_wr_data = wd;
  endtask

  initial begin
    logic mg, dg;
    for (int i = 0; i < int'(Depth); i++) begin
      spm_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    spm_rd_q = '0;
    reset = 1'b1;
    set_m(1'b0, 1'b0, '0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    repeat (3) step();
    reset = 1'b0;
    step();

    // MEM read alone
    set_m(1'b1, 1'b1, 12'h010, '0);
    step();
    set_m(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t1_rd_data", m_rd_data, init_word(32'h010));
    step();

    // DMA write then MEM read of the same address
    set_d(1'b1, 1'b0, 12'h020, 32'hDEAD_BEEF);
    step();
    set_d(1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b1, 12'h020, '0);
    step();
    set_m(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t2_rd_data", m_rd_data, 32'hDEAD_BEEF);
    step();
    step();

    // Sustained contention: DMA forced every (SM+1)th cycle
    set_m(1'b1, 1'b1, 12'h030, '0);
    set_d(1'b1, 1'b1, 12'h040, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_d_gnt", d_gnt, (i % 5) == 4);
      step();
    end
    set_m(1'b0, 1'b0, '0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    step();
    step();

    // Pipelined reads MEM, DMA, MEM
    set_m(1'b1, 1'b1, 12'h051, '0);
    step();
    set_m(1'b0, 1'b0, '0, '0);
    set_d(1'b1, 1'b1, 12'h052, '0);
    step();
    set_d(1'b0, 1'b0, '0, '0);
    set_m(1'b1, 1'b1, 12'h053, '0);
    step();
    set_m(1'b0, 1'b0, '0, '0);
    step();
    step();

    // Reset in the cycle after a granted read; MEM first after release
    set_m(1'b1, 1'b1, 12'h060, '0);
    step();
    set_m(1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_m(1'b1, 1'b0, 12'h061, 32'h0BAD_F00D);
    set_d(1'b1, 1'b0, 12'h062, 32'h1357_9BDF);
    @(negedge clk);
    check("t5_mem_first", {m_gnt, d_gnt}, 2'b10);
    step();
    set_m(1'b0, 1'b0, '0, '0);
    step();
    set_d(1'b0, 1'b0, '0, '0);

    // Idle
    repeat (5) step();

    // Randomized traffic; requests are held until granted
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mg = m_gnt;
      dg = d_gnt;
      step();
      reset = ($urandom_range(0, 99) == 0);
      if (!(m_req && !mg))
        set_m($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 15)), $urandom);
      if (!(d_req && !dg))
        set_d($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 15)), $urandom);
    end
    reset = 1'b0;
    set_m(1'b0, 1'b0, '0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    repeat (4) step();
    @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
